// File: rtl/video_sync_gen.sv
// video_sync_gen: PAL/NTSC-rate horizontal, vertical and composite sync
// generator. Non-interlaced, one field per frame. The vsync_out stream it
// produces is the one the VSYNC-period format detector measures, so it also
// serves as a loopback stimulus for that detector.

package video_sync_pkg;

  // Format encoding shared with the format detector.
  localparam logic FORMAT_PAL  = 1'b1;
  localparam logic FORMAT_NTSC = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : video_sync_pkg

module video_sync_gen
  import video_sync_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,  // clk_in frequency, Hz
  parameter int LINE_PAL    = 3200,        // ticks per PAL line
  parameter int LINE_NTSC   = 3175,        // ticks per NTSC line
  parameter int LINES_PAL   = 312,         // lines per PAL field
  parameter int LINES_NTSC  = 262,         // lines per NTSC field
  parameter int HSYNC_TICKS = 235,         // hsync low width, ticks
  parameter int VSYNC_LINES = 3            // vsync low width, lines from line 0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       enable_in,
  input  logic       format_in,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       csync_out,
  output logic       field_start,
  output logic       format_active,
  output logic [8:0] line_out
);

  // Parameter sanity: the counters are 12 and 9 bits wide, and both sync
  // pulses must end inside their period or the outputs would never toggle.
  if (CLK_FREQ <= 0) begin : g_bad_clk
    $error("video_sync_gen: CLK_FREQ must be positive");
  end
  if (LINE_PAL >= 4096 || LINE_NTSC >= 4096 || LINE_PAL < 2 || LINE_NTSC < 2)
  begin : g_bad_line
    $error("video_sync_gen: line length must be in 2..4095 ticks");
  end
  if (LINES_PAL >= 512 || LINES_NTSC >= 512 || LINES_PAL < 2 || LINES_NTSC < 2)
  begin : g_bad_lines
    $error("video_sync_gen: field length must be in 2..511 lines");
  end
  if (HSYNC_TICKS >= LINE_PAL || HSYNC_TICKS >= LINE_NTSC) begin : g_bad_hsync
    $error("video_sync_gen: HSYNC_TICKS must be shorter than a line");
  end
  if (VSYNC_LINES >= LINES_PAL || VSYNC_LINES >= LINES_NTSC) begin : g_bad_vsync
    $error("video_sync_gen: VSYNC_LINES must be shorter than a field");
  end

  // Terminal counts and pulse widths, sized to the counters they are
  // compared against.
  localparam logic [11:0] LINE_PAL_LAST   = 12'(LINE_PAL - 1);
  localparam logic [11:0] LINE_NTSC_LAST  = 12'(LINE_NTSC - 1);
  localparam logic [8:0]  LINES_PAL_LAST  = 9'(LINES_PAL - 1);
  localparam logic [8:0]  LINES_NTSC_LAST = 9'(LINES_NTSC - 1);
  localparam logic [11:0] HSYNC_W         = 12'(HSYNC_TICKS);
  localparam logic [8:0]  VSYNC_W         = 9'(VSYNC_LINES);

  state_t      state;
  logic [11:0] h_cnt;
  logic [8:0]  v_cnt;

  logic [11:0] line_last;
  logic [8:0]  lines_last;
  logic        h_wrap;
  logic        v_wrap;
  logic        hsync_act;
  logic        vsync_act;
  logic        field_origin;

  // Field geometry follows format_active, which only moves at a field
  // boundary, so a mid-field format request cannot stretch or cut a field.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missed
    // branch in combinational logic would otherwise infer a latch.
    line_last  = LINE_NTSC_LAST;
    lines_last = LINES_NTSC_LAST;
    if (format_active == FORMAT_PAL) begin
      line_last  = LINE_PAL_LAST;
      lines_last = LINES_PAL_LAST;
    end
  end

  assign h_wrap       = (h_cnt == line_last);
  assign v_wrap       = (v_cnt == lines_last);
  assign hsync_act    = (h_cnt < HSYNC_W);
  assign vsync_act    = (v_cnt < VSYNC_W);
  assign field_origin = (h_cnt == 12'd0) && (v_cnt == 9'd0);

  // Timing FSM: counters, format latch and registered sync outputs.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_in) begin
      state         <= IDLE;
      h_cnt         <= 12'd0;
      v_cnt         <= 9'd0;
      hsync_out     <= 1'b1;
      vsync_out     <= 1'b1;
      csync_out     <= 1'b1;
      field_start   <= 1'b0;
      line_out      <= 9'd0;
      format_active <= FORMAT_NTSC;
    end else begin
      case (state)
        IDLE: begin
          h_cnt       <= 12'd0;
          v_cnt       <= 9'd0;
          hsync_out   <= 1'b1;
          vsync_out   <= 1'b1;
          csync_out   <= 1'b1;
          field_start <= 1'b0;
          line_out    <= 9'd0;
          if (enable_in) begin
            // Counters are already at the field origin, so the first field
            // begins on the very next cycle in the requested format.
            state         <= RUN;
            format_active <= format_in;
          end
        end

        RUN: begin
          if (!enable_in) begin
            state       <= IDLE;
            h_cnt       <= 12'd0;
            v_cnt       <= 9'd0;
            hsync_out   <= 1'b1;
            vsync_out   <= 1'b1;
            csync_out   <= 1'b1;
            field_start <= 1'b0;
            line_out    <= 9'd0;
          end else begin
            // Outputs trail the counters by one cycle.
            hsync_out   <= !hsync_act;
            vsync_out   <= !vsync_act;
            csync_out   <= !hsync_act && !vsync_act;
            field_start <= field_origin;
            line_out    <= v_cnt;

            if (h_wrap) begin
              h_cnt <= 12'd0;
              if (v_wrap) begin
                // Field boundary: the only place a new format is taken.
                v_cnt         <= 9'd0;
                format_active <= format_in;
              end else begin
                v_cnt <= v_cnt + 9'd1;
              end
            end else begin
              h_cnt <= h_cnt + 12'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : video_sync_gen

// File: tb/tb_video_sync_gen.sv
// tb_video_sync_gen: self-checking bench for video_sync_gen using shrunken
// line/field geometry so several whole fields fit in a short run. A cycle
// model predicts every output and feeds a scoreboard queue; a table of
// per-format timing records checks measured periods and widths; short
// hand-written sequences cover format change, disable, and reset.

module tb_video_sync_gen;

  // Reduced geometry: PAL 40 x 12 = 480 cycles/field, NTSC 30 x 10 = 300.
  localparam int LP = 40;
  localparam int LN = 30;
  localparam int NP = 12;
  localparam int NN = 10;
  localparam int HS = 5;
  localparam int VL = 3;

  localparam logic PAL  = 1'b1;
  localparam logic NTSC = 1'b0;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       enable_in = 1'b0;
  logic       format_in = 1'b0;
  logic       hsync_out;
  logic       vsync_out;
  logic       csync_out;
  logic       field_start;
  logic       format_active;
  logic [8:0] line_out;

  video_sync_gen #(
    .CLK_FREQ   (50_000_000),
    .LINE_PAL   (LP),
    .LINE_NTSC  (LN),
    .LINES_PAL  (NP),
    .LINES_NTSC (NN),
    .HSYNC_TICKS(HS),
    .VSYNC_LINES(VL)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .enable_in    (enable_in),
    .format_in    (format_in),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .csync_out    (csync_out),
    .field_start  (field_start),
    .format_active(format_active),
    .line_out     (line_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       cs;
    logic       fs;
    logic       fa;
    logic [8:0] line;
  } obs_t;

  typedef struct {
    logic fmt;
    int   vs_period;
    int   vs_low;
    int   hs_period;
    int   hs_low;
    int   last_line;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  obs_t sb_q[$];

  // Bench model of the generator: position within the field, not h/v.
  bit   m_run = 1'b0;
  int   m_pos = 0;
  logic m_fmt = NTSC;

  // Edge timestamps collected while stepping.
  int   vf[$];
  int   vr[$];
  int   hf[$];
  int   hr[$];
  int   fs_t[$];
  int   max_line;
  logic prev_vs = 1'b1;
  logic prev_hs = 1'b1;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic clear_meas();
    vf.delete();
    vr.delete();
    hf.delete();
    hr.delete();
    fs_t.delete();
    max_line = 0;
  endtask

  // One clock: predict, push, clock, sample #1 after the edge, pop, compare.
  task automatic step();
    obs_t e;
    obs_t got;
    int   len;
    int   cnt;
    int   h;
    int   v;
    e = '{hs: 1'b1, vs: 1'b1, cs: 1'b1, fs: 1'b0, fa: 1'b0, line: 9'd0};
    if (rst_in) begin
      m_run = 1'b0;
      m_pos = 0;
      m_fmt = NTSC;
    end else if (!m_run) begin
      if (enable_in) begin
        m_run = 1'b1;
        m_pos = 0;
        m_fmt = format_in;
      end
    end else if (!enable_in) begin
      m_run = 1'b0;
      m_pos = 0;
    end else begin
      len    = (m_fmt == PAL) ? LP : LN;
      cnt    = (m_fmt == PAL) ? NP : NN;
      h      = m_pos % len;
      v      = m_pos / len;
      e.hs   = (h >= HS);
      e.vs   = (v >= VL);
      e.cs   = e.hs & e.vs;
      e.fs   = (m_pos == 0);
      e.line = v[8:0];
      m_pos++;
      if (m_pos == len * cnt) begin
        m_pos = 0;
        m_fmt = format_in;
      end
    end
    e.fa = m_fmt;
    sb_q.push_back(e);

    @(posedge clk_in);
    #1;
    cyc++;
    got = {hsync_out, vsync_out, csync_out, field_start, format_active, line_out};
    e = sb_q.pop_front();
    check("scoreboard", 32'(got), 32'(e));

    if (prev_vs && !vsync_out) vf.push_back(cyc);
    if (!prev_vs && vsync_out) vr.push_back(cyc);
    if (prev_hs && !hsync_out) hf.push_back(cyc);
    if (!prev_hs && hsync_out) hr.push_back(cyc);
    if (field_start) fs_t.push_back(cyc);
    if (int'(line_out) > max_line) max_line = int'(line_out);
    prev_vs = vsync_out;
    prev_hs = hsync_out;
  endtask

  task automatic do_reset();
    rst_in    = 1'b1;
    enable_in = 1'b0;
    repeat (2) step();
    rst_in = 1'b0;
  endtask

  vec_t vecs[2];

  initial begin
    int d;

    // Expected timing per format, worked out by hand from the geometry.
    vecs[0] = '{fmt: PAL,  vs_period: 480, vs_low: 120, hs_period: 40,
                hs_low: 5, last_line: 11};
    vecs[1] = '{fmt: NTSC, vs_period: 300, vs_low: 90,  hs_period: 30,
                hs_low: 5, last_line: 9};

    // Reset state.
    rst_in = 1'b1;
    step();
    check("reset_outputs",
          {27'd0, hsync_out, vsync_out, csync_out, field_start, format_active},
          {27'd0, 5'b11100});
    check("reset_line", 32'(line_out), 32'd0);
    step();
    rst_in = 1'b0;

    // Free-running timing per format.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      format_in = vecs[r].fmt;
      enable_in = 1'b1;
      clear_meas();
      repeat (1100) step();
      d = (vf.size() >= 2) ? vf[1] - vf[0] : -1;
      check("vsync_period", 32'(d), 32'(vecs[r].vs_period));
      check("detector_class", 32'(d > 390), 32'(vecs[r].fmt));
      d = (vf.size() >= 1 && vr.size() >= 1) ? vr[0] - vf[0] : -1;
      check("vsync_low", 32'(d), 32'(vecs[r].vs_low));
      d = (hf.size() >= 2) ? hf[1] - hf[0] : -1;
      check("hsync_period", 32'(d), 32'(vecs[r].hs_period));
      d = (hf.size() >= 1 && hr.size() >= 1) ? hr[0] - hf[0] : -1;
      check("hsync_low", 32'(d), 32'(vecs[r].hs_low));
      check("last_line", 32'(max_line), 32'(vecs[r].last_line));
      check("format_active", 32'(format_active), 32'(vecs[r].fmt));
      d = (fs_t.size() >= 1 && vf.size() >= 1) ? fs_t[0] - vf[0] : -1;
      check("fs_with_vsync", 32'(d), 32'd0);
    end

    // Format change mid-field: current field keeps PAL length.
    do_reset();
    format_in = PAL;
    enable_in = 1'b1;
    clear_meas();
    for (int i = 0; i < 1000 && !(vf.size() >= 1 && line_out == 9'd5); i++) step();
    check("wait_line5_pal", 32'(line_out), 32'd5);
    format_in = NTSC;
    check("fa_before_switch", 32'(format_active), 32'(PAL));
    for (int i = 0; i < 2000 && fs_t.size() < 2; i++) step();
    check("fs_count", 32'(fs_t.size()), 32'd2);
    check("fa_at_field_start", {30'd0, field_start, format_active}, {30'd0, 1'b1, NTSC});
    for (int i = 0; i < 2000 && vf.size() < 3; i++) step();
    d = (vf.size() >= 2) ? vf[1] - vf[0] : -1;
    check("field_kept_pal", 32'(d), 32'd480);
    d = (vf.size() >= 3) ? vf[2] - vf[1] : -1;
    check("next_field_ntsc", 32'(d), 32'd300);

    // Disable mid-field, then re-enable.
    for (int i = 0; i < 1000 && line_out != 9'd5; i++) step();
    check("wait_line5_ntsc", 32'(line_out), 32'd5);
    enable_in = 1'b0;
    step();
    check("disable_idle", {20'd0, hsync_out, vsync_out, csync_out, line_out},
          {20'd0, 3'b111, 9'd0});
    repeat (3) step();
    enable_in = 1'b1;
    step();
    check("reenable_no_fs_yet", 32'(field_start), 32'd0);
    step();
    check("reenable_fs", {29'd0, field_start, hsync_out, vsync_out},
          {29'd0, 3'b100});

    // Reset pulsed during hsync low, held with enable high.
    for (int i = 0; i < 1000 && line_out != 9'd2; i++) step();
    for (int i = 0; i < 100 && hsync_out != 1'b0; i++) step();
    check("wait_hsync_low", 32'(hsync_out), 32'd0);
    format_in = PAL;
    rst_in    = 1'b1;
    step();
    check("rst_mid_hsync",
          {18'd0, hsync_out, vsync_out, csync_out, field_start, format_active, line_out},
          {18'd0, 5'b11100, 9'd0});
    repeat (3) step();
    check("rst_held_idle", {29'd0, hsync_out, field_start, format_active},
          {29'd0, 1'b1, 1'b0, NTSC});
    rst_in = 1'b0;
    step();
    check("restart_latch", {30'd0, field_start, format_active}, {30'd0, 1'b0, PAL});
    step();
    check("restart_fs", 32'(field_start), 32'd1);
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_video_sync_gen
